delay_ctrl: RTL



---
 rtl/delay_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/delay_ctrl.sv
// ---------------------------------------------------------------------------
// delay_ctrl
//
// Parameter sequencer in front of the delay effect block. User targets for
// delay length, feedback and blend are captured on `load` and applied
// without clicks: blend (and feedback, when muting is enabled) ramps down
// to zero, the tap length slews toward its target by at most DLY_STEP per
// sample tick, then blend/feedback ramp back up to their targets.
// Every output step happens only on a clock edge where `tick` is high.
//
// Ports:
//   clk         in   system / audio clock
//   reset_n     in   asynchronous active-low reset
//   tick        in   one-cycle sample strobe (same as delay.valid)
//   load        in   one-cycle strobe, captures the three targets
//   tgt_delay   in   [DLY_B-1:0]   requested delay length
//   tgt_feedbk  in   [FDB_B-1:0]   requested feedback
//   tgt_blend   in   [BLEND_B-1:0] requested blend
//   delay       out  [DLY_B-1:0]   applied delay length
//   feedbk      out  [FDB_B-1:0]   applied feedback
//   blend       out  [BLEND_B-1:0] applied blend
//   busy        out  high whenever the sequencer is not idle
//
// Build option:
//   DELAY_CTRL_FDB_MUTE_EN  defined   : feedback is muted/restored together
//                                       with blend.
//                           undefined : feedback follows its target on the
//                                       next tick and the mute/restore ramps
//                                       depend on blend only.
// ---------------------------------------------------------------------------
module delay_ctrl #(
    parameter int DLY_B    = 13,
    parameter int FDB_B    = 10,
    parameter int BLEND_B  = 4,
    parameter int DLY_STEP = 1,
    parameter int DLY_RST  = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               load,
    input  logic [DLY_B-1:0]   tgt_delay,
    input  logic [FDB_B-1:0]   tgt_feedbk,
    input  logic [BLEND_B-1:0] tgt_blend,
    output logic [DLY_B-1:0]   delay,
    output logic [FDB_B-1:0]   feedbk,
    output logic [BLEND_B-1:0] blend,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUTE    = 2'd1,
        SLEW    = 2'd2,
        RESTORE = 2'd3
    } state_t;

    localparam logic [DLY_B-1:0] DLY_RST_V = DLY_B'(DLY_RST);
    localparam logic [DLY_B-1:0] STEP_N    = DLY_B'(DLY_STEP);
    localparam logic [DLY_B:0]   STEP_W    = (DLY_B+1)'(DLY_STEP);

    state_t               state_q, state_d;
    logic [DLY_B-1:0]     delay_q, delay_d;
    logic [FDB_B-1:0]     feedbk_q, feedbk_d;
    logic [BLEND_B-1:0]   blend_q, blend_d;
    logic [DLY_B-1:0]     t_dly_q, t_dly_d;
    logic [FDB_B-1:0]     t_fdb_q, t_fdb_d;
    logic [BLEND_B-1:0]   t_bld_q, t_bld_d;

    // One slew step of the tap length. The difference is taken one bit wider
    // than the operands so the sign is exact; a remaining distance within
    // DLY_STEP lands exactly on the target, so the result never overshoots
    // and never wraps.
    function automatic logic [DLY_B-1:0] slew_step(input logic [DLY_B-1:0] cur,
                                                   input logic [DLY_B-1:0] tgt);
        logic signed [DLY_B:0] diff;
        logic        [DLY_B:0] mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[DLY_B] ? $unsigned(-diff) : $unsigned(diff);
        if (mag <= STEP_W) begin
            return tgt;
        end else if (diff[DLY_B]) begin
            return cur - STEP_N;
        end else begin
            return cur + STEP_N;
        end
    endfunction

    // Move blend one unit toward a target; muting is a ramp toward zero.
    function automatic logic [BLEND_B-1:0] bld_toward(input logic [BLEND_B-1:0] cur,
                                                      input logic [BLEND_B-1:0] tgt);
        if (cur < tgt) begin
            return cur + BLEND_B'(1);
        end else if (cur > tgt) begin
            return cur - BLEND_B'(1);
        end else begin
            return cur;
        end
    endfunction

`ifdef DELAY_CTRL_FDB_MUTE_EN
    function automatic logic [FDB_B-1:0] fdb_toward(input logic [FDB_B-1:0] cur,
                                                    input logic [FDB_B-1:0] tgt);
        if (cur < tgt) begin
            return cur + FDB_B'(1);
        end else if (cur > tgt) begin
            return cur - FDB_B'(1);
        end else begin
            return cur;
        end
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        delay_d  = delay_q;
        feedbk_d = feedbk_q;
        blend_d  = blend_q;
        t_dly_d  = t_dly_q;
        t_fdb_d  = t_fdb_q;
        t_bld_d  = t_bld_q;

        if (load) begin
            // A load edge only captures and re-evaluates; no output step is
            // taken even if tick is also high.
            t_dly_d = tgt_delay;
            t_fdb_d = tgt_feedbk;
            t_bld_d = tgt_blend;
            case (state_q)
                IDLE, RESTORE: state_d = (tgt_delay != delay_q) ? MUTE : RESTORE;
                default:       state_d = state_q;
            endcase
        end else begin
            case (state_q)
                MUTE: begin
                    if (tick) begin
                        blend_d = bld_toward(blend_q, '0);
`ifdef DELAY_CTRL_FDB_MUTE_EN
                        feedbk_d = fdb_toward(feedbk_q, '0);
`endif
                    end
                    // Completion is judged on the post-step values so the
                    // final decrement and the state change share one edge.
`ifdef DELAY_CTRL_FDB_MUTE_EN
                    if ((blend_d == '0) && (feedbk_d == '0)) begin
`else
                    if (blend_d == '0) begin
`endif
                        state_d = SLEW;
                    end
                end
                SLEW: begin
                    if (tick) begin
                        delay_d = slew_step(delay_q, t_dly_q);
                    end
                    if (delay_d == t_dly_q) begin
                        state_d = RESTORE;
                    end
                end
                RESTORE: begin
                    if (tick) begin
                        blend_d = bld_toward(blend_q, t_bld_q);
`ifdef DELAY_CTRL_FDB_MUTE_EN
                        feedbk_d = fdb_toward(feedbk_q, t_fdb_q);
`endif
                    end
`ifdef DELAY_CTRL_FDB_MUTE_EN
                    if ((blend_d == t_bld_q) && (feedbk_d == t_fdb_q)) begin
`else
                    if (blend_d == t_bld_q) begin
`endif
                        state_d = IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
`ifndef DELAY_CTRL_FDB_MUTE_EN
            // Feedback is not ramped: it jumps to the captured target on the
            // first tick after capture, whatever the sequencer is doing.
            if (tick) begin
                feedbk_d = t_fdb_q;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            delay_q  <= DLY_RST_V;
            feedbk_q <= '0;
            blend_q  <= '0;
            t_dly_q  <= DLY_RST_V;
            t_fdb_q  <= '0;
            t_bld_q  <= '0;
        end else begin
            state_q  <= state_d;
            delay_q  <= delay_d;
            feedbk_q <= feedbk_d;
            blend_q  <= blend_d;
            t_dly_q  <= t_dly_d;
            t_fdb_q  <= t_fdb_d;
            t_bld_q  <= t_bld_d;
        end
    end

    assign delay  = delay_q;
    assign feedbk = feedbk_q;
    assign blend  = blend_q;
    assign busy   = (state_q != IDLE);

endmodule
